serial_magnitude_comparator: RTL and testbench
==============================================

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 Parameter EARLY_EXIT, default 0; 1 = finish as soon as the first differing bit is found.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  request a comparison; sampled only when the block can accept.
REQ-007 a  input  WIDTH  operand A; sampled in the cycle start is accepted.
REQ-008 b  input  WIDTH  operand B; sampled in the cycle start is accepted.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 eq, lt, gt  output  1 each  result flags: A==B, A<B, A>B; one-hot when valid.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 start is accepted in IDLE or DONE; start in SHIFT SHALL be ignored, with no effect on the operation in progress.
REQ-014 On acceptance at edge t, the block SHALL load a and b into shift registers, set cascade state e=1, l=0, g=0, set bit index to WIDTH-1 and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL process one bit pair, MSB first, through the bit slice, using the cascade state as slice input and registering the slice output as the new cascade state.
REQ-016 The cascade rule SHALL be: if l or g is already set, keep it; else if a_bit>b_bit, set g; else if a_bit<b_bit, set l; else keep e.
REQ-017 With SIGNED=1, the MSB step SHALL use inverted sense: a_msb=1, b_msb=0 sets l; the reverse sets g.
REQ-018 With EARLY_EXIT=0, SHIFT SHALL last exactly WIDTH cycles; done SHALL be high in cycle t+WIDTH+1.
REQ-019 With EARLY_EXIT=1, the block SHALL leave SHIFT after the cycle in which l or g first becomes set, or after bit 0, whichever comes first.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unless a new start is accepted in DONE.
REQ-021 A start accepted in DONE SHALL go directly to SHIFT, giving back-to-back operation with no idle cycle.
REQ-022 busy SHALL be 1 exactly in SHIFT.
REQ-023 eq/lt/gt SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-024 eq/lt/gt SHALL NOT change during SHIFT.
REQ-025 a and b changing after acceptance SHALL NOT affect the result.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, eq=0, lt=0, gt=0, and clear the shift registers, bit index and cascade state.
REQ-027 Reset SHALL take priority over start; an in-progress comparison interrupted by reset SHALL produce no done.

Structure
REQ-028 A shared package serial_cmp_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the cascade-state struct {e, l, g}.
REQ-029 The one-bit cascade step SHALL be a combinational sub-module, cmp_bit_slice, with ports a, b, e_in, l_in, g_in, e_out, l_out, g_out; it is instantiated once and reused every cycle.
REQ-030 The bit index counter SHALL be $clog2(WIDTH) bits wide.

Verification
REQ-031 WIDTH=8, unsigned, a=0x5A, b=0x5A, start one cycle -> done at t+9; eq=1, lt=0, gt=0; busy high 8 cycles.
REQ-032 WIDTH=8, SIGNED=1, a=0x80 (-128), b=0x01 -> lt=1. Same operands with SIGNED=0 -> gt=1.
REQ-033 EARLY_EXIT=1, a=0x80, b=0x00 -> done at t+2, gt=1. a=0x01, b=0x00 -> done at t+9, gt=1.
REQ-034 Back-to-back: start held high continuously with (0x10,0x20) then (0x30,0x20) -> two done pulses 9 cycles apart, results lt then gt. A start pulse during SHIFT is ignored.
REQ-035 rst asserted at cycle t+4 mid-operation -> next cycle all outputs 0, state IDLE, no done. A fresh start afterwards completes normally.
REQ-036 Randomised compare of 1000 operand pairs, both SIGNED settings, against a reference model; eq/lt/gt SHALL always be one-hot at done.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the three-flag cascade state carried from one bit step to the next.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic e;
        logic l;
        logic g;
    } cascade_t;

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit magnitude cascade step: once a decision (l or g) exists it sticks,
// otherwise the current bit pair decides or equality carries through.
module cmp_bit_slice (
    input  logic a,
    input  logic b,
    input  logic e_in,
    input  logic l_in,
    input  logic g_in,
    output logic e_out,
    output logic l_out,
    output logic g_out
);

    // Cascade rule for a single bit pair
    always_comb begin
        e_out = e_in;
        l_out = l_in;
        g_out = g_in;
        if (l_in || g_in) begin
            e_out = 1'b0;
        end else if (a && !b) begin
            g_out = 1'b1;
            e_out = 1'b0;
        end else if (!a && b) begin
            l_out = 1'b1;
            e_out = 1'b0;
        end else begin
            e_out = e_in;
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator; one bit pair per SHIFT cycle
// through a single reused bit slice, result flags registered on entry to DONE.
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [IDX_W-1:0] idx_r;
    cascade_t         cas_r;
    cascade_t         cas_nxt_s;
    logic             accept_s;
    logic             msb_s;
    logic             a_bit_s;
    logic             b_bit_s;
    logic             busy_r;
    logic             done_r;
    logic             eq_r;
    logic             lt_r;
    logic             gt_r;

    // Bit selection; in signed mode the sign bit is compared with swapped sense
    always_comb begin
        accept_s = start && (state_r != SHIFT);
        msb_s    = (idx_r == IDX_W'(WIDTH - 1));
        if ((SIGNED != 0) && msb_s) begin
            a_bit_s = b_sh_r[WIDTH-1];
            b_bit_s = a_sh_r[WIDTH-1];
        end else begin
            a_bit_s = a_sh_r[WIDTH-1];
            b_bit_s = b_sh_r[WIDTH-1];
        end
    end

    cmp_bit_slice u_slice (
        .a     (a_bit_s),
        .b     (b_bit_s),
        .e_in  (cas_r.e),
        .l_in  (cas_r.l),
        .g_in  (cas_r.g),
        .e_out (cas_nxt_s.e),
        .l_out (cas_nxt_s.l),
        .g_out (cas_nxt_s.g)
    );

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = SHIFT;
                else          state_nxt_s = IDLE;
            end
            SHIFT: begin
                if ((idx_r == '0) ||
                    ((EARLY_EXIT != 0) && (cas_nxt_s.l || cas_nxt_s.g)))
                    state_nxt_s = DONE;
                else
                    state_nxt_s = SHIFT;
            end
            DONE: begin
                if (accept_s) state_nxt_s = SHIFT;
                else          state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            idx_r   <= '0;
            cas_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            eq_r    <= 1'b0;
            lt_r    <= 1'b0;
            gt_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == SHIFT);
            done_r  <= (state_nxt_s == DONE);
            if (accept_s) begin
                a_sh_r <= a;
                b_sh_r <= b;
                cas_r  <= '{e: 1'b1, l: 1'b0, g: 1'b0};
                idx_r  <= IDX_W'(WIDTH - 1);
            end else if (state_r == SHIFT) begin
                a_sh_r <= {a_sh_r[WIDTH-2:0], 1'b0};
                b_sh_r <= {b_sh_r[WIDTH-2:0], 1'b0};
                cas_r  <= cas_nxt_s;
                idx_r  <= idx_r - IDX_W'(1);
            end else begin
                a_sh_r <= a_sh_r;
                b_sh_r <= b_sh_r;
                cas_r  <= cas_r;
                idx_r  <= idx_r;
            end
            if ((state_r == SHIFT) && (state_nxt_s == DONE)) begin
                eq_r <= cas_nxt_s.e;
                lt_r <= cas_nxt_s.l;
                gt_r <= cas_nxt_s.g;
            end else begin
                eq_r <= eq_r;
                lt_r <= lt_r;
                gt_r <= gt_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign eq   = eq_r;
    assign lt   = lt_r;
    assign gt   = gt_r;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: three comparators (unsigned, signed, unsigned early-exit)
// share one stimulus stream and are checked against an arithmetic reference.
module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy_w [3];
    logic       done_w [3];
    logic       eq_w   [3];
    logic       lt_w   [3];
    logic       gt_w   [3];

    int         n_cmp;
    int         n_bad;
    int         done_cyc [3];
    logic [2:0] res_q    [3];
    int         busy_cnt;
    int         done_cnt;
    bit         held_ok;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp_u;
        logic [2:0] exp_s;
        int         exp_early;
    } vec_t;

    serial_magnitude_comparator #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(0)) u_uns (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_w[0]), .done(done_w[0]), .eq(eq_w[0]), .lt(lt_w[0]), .gt(gt_w[0]));
    serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(0)) u_sgn (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_w[1]), .done(done_w[1]), .eq(eq_w[1]), .lt(lt_w[1]), .gt(gt_w[1]));
    serial_magnitude_comparator #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(1)) u_early (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_w[2]), .done(done_w[2]), .eq(eq_w[2]), .lt(lt_w[2]), .gt(gt_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] flags(input int i);
        return {eq_w[i], lt_w[i], gt_w[i]};
    endfunction

    // Reference: plain integer comparison, result as {eq, lt, gt}
    function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y, input bit sgn);
        int sx;
        int sy;
        sx = sgn ? int'($signed(x)) : int'(x);
        sy = sgn ? int'($signed(y)) : int'(y);
        if (sx == sy)     return 3'b100;
        else if (sx < sy) return 3'b010;
        else              return 3'b001;
    endfunction

    // Early-exit latency: bits examined up to and including the first difference, plus one
    function automatic int ref_early(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        d = x ^ y;
        for (int p = 7; p >= 0; p--) begin
            if (d[p]) return (8 - p) + 1;
        end
        return 9;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One operation; operands are scrambled right after acceptance
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv);
        logic [2:0] prev0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        prev0 = flags(0);
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = ~bv;
        for (int i = 0; i < 3; i++) begin
            done_cyc[i] = 0;
            res_q[i]    = 3'b000;
        end
        busy_cnt = 0; held_ok = 1'b1; done_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (busy_w[0]) busy_cnt++;
            if (done_w[0]) done_cnt++;
            for (int i = 0; i < 3; i++) begin
                if (done_cyc[i] == 0 && done_w[i]) begin
                    done_cyc[i] = c;
                    res_q[i]    = flags(i);
                end
            end
            if (done_cyc[0] == 0 && flags(0) != prev0) held_ok = 1'b0;
        end
    endtask

    vec_t vecs [10];

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;

        vecs[0] = '{8'h5A, 8'h5A, 3'b100, 3'b100, 9};
        vecs[1] = '{8'h80, 8'h01, 3'b001, 3'b010, 2};
        vecs[2] = '{8'h80, 8'h00, 3'b001, 3'b010, 2};
        vecs[3] = '{8'h01, 8'h00, 3'b001, 3'b001, 9};
        vecs[4] = '{8'h10, 8'h20, 3'b010, 3'b010, 4};
        vecs[5] = '{8'h30, 8'h20, 3'b001, 3'b001, 5};
        vecs[6] = '{8'hFF, 8'h00, 3'b001, 3'b010, 2};
        vecs[7] = '{8'h7F, 8'h80, 3'b010, 3'b001, 2};
        vecs[8] = '{8'h00, 8'hFF, 3'b010, 3'b001, 2};
        vecs[9] = '{8'hFE, 8'hFF, 3'b010, 3'b010, 9};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", int'(busy_w[i]), 0);
            check("reset_done", int'(done_w[i]), 0);
            check("reset_flags", int'(flags(i)), 0);
        end
        @(negedge clk); rst = 1'b0;

        // Directed table
        for (int v = 0; v < 10; v++) begin
            do_op(vecs[v].a, vecs[v].b);
            check("tbl_done_cycle", done_cyc[0], 9);
            check("tbl_unsigned", int'(res_q[0]), int'(vecs[v].exp_u));
            check("tbl_signed", int'(res_q[1]), int'(vecs[v].exp_s));
            check("tbl_signed_cycle", done_cyc[1], 9);
            check("tbl_early_cycle", done_cyc[2], vecs[v].exp_early);
            check("tbl_early_result", int'(res_q[2]), int'(vecs[v].exp_u));
            check("tbl_busy_cycles", busy_cnt, 8);
            check("tbl_done_pulses", done_cnt, 1);
            check("tbl_flags_held", int'(held_ok), 1);
        end

        // Back-to-back with start held high
        begin
            int  d1, d2;
            logic [2:0] r1, r2;
            bit  drop;
            d1 = 0; d2 = 0; r1 = 3'b000; r2 = 3'b000; drop = 1'b0;
            @(negedge clk);
            a = 8'h10; b = 8'h20; start = 1'b1;
            @(posedge clk); #1;
            a = 8'h30; b = 8'h20;
            for (int c = 1; c <= 30; c++) begin
                if (c > 1) begin
                    @(posedge clk); #1;
                    if (drop) begin start = 1'b0; drop = 1'b0; end
                end
                if (done_w[0]) begin
                    if (d1 == 0) begin d1 = c; r1 = flags(0); drop = 1'b1; end
                    else if (d2 == 0) begin d2 = c; r2 = flags(0); end
                end
            end
            start = 1'b0;
            check("b2b_first_cycle", d1, 9);
            check("b2b_spacing", d2 - d1, 9);
            check("b2b_first_lt", int'(r1), 3'b010);
            check("b2b_second_gt", int'(r2), 3'b001);
        end

        // Start pulse during SHIFT is ignored
        begin
            int dc;
            int nd;
            logic [2:0] r;
            dc = 0; nd = 0; r = 3'b000;
            @(negedge clk);
            a = 8'h30; b = 8'h40; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 1; c <= 14; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                if (c == 3) begin a = 8'h90; b = 8'h20; start = 1'b1; end
                if (c == 4) start = 1'b0;
                if (done_w[0]) begin
                    nd++;
                    if (dc == 0) begin dc = c; r = flags(0); end
                end
            end
            check("ignore_done_cycle", dc, 9);
            check("ignore_result", int'(r), 3'b010);
            check("ignore_pulses", nd, 1);
        end

        // Reset mid-operation
        begin
            int nd;
            nd = 0;
            @(negedge clk);
            a = 8'h5A; b = 8'h5B; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("rst_mid_busy", int'(busy_w[0]), 0);
            check("rst_mid_done", int'(done_w[0]), 0);
            check("rst_mid_flags", int'(flags(0)), 0);
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done_w[0] || done_w[1] || done_w[2]) nd++;
            end
            check("rst_mid_no_done", nd, 0);
            do_op(8'h5A, 8'h5B);
            check("rst_fresh_cycle", done_cyc[0], 9);
            check("rst_fresh_result", int'(res_q[0]), 3'b010);
        end

        // Randomised operands against the reference model
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (n % 8 == 0) ? ra : 8'($urandom);
            do_op(ra, rb);
            check("rnd_unsigned", int'(res_q[0]), int'(ref_flags(ra, rb, 1'b0)));
            check("rnd_signed", int'(res_q[1]), int'(ref_flags(ra, rb, 1'b1)));
            check("rnd_early", int'(res_q[2]), int'(ref_flags(ra, rb, 1'b0)));
            check("rnd_early_cycle", done_cyc[2], ref_early(ra, rb));
            check("rnd_done_cycle", done_cyc[0], 9);
            check("rnd_onehot_u", $countones(res_q[0]), 1);
            check("rnd_onehot_s", $countones(res_q[1]), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
